ws2812_unipolar_rz_decoder: RTL
===============================

# ws2812_unipolar_rz_decoder

Receive-side counterpart of the WS2812 unipolar RZ encoder. Samples a single-wire WS2812 data line, measures each high pulse, and emits one decoded bit per pulse with a one-cycle strobe. Also flags reset gaps and malformed pulses. Used for loopback checking of the transmit path and for daisy-chain sniffing/repeating; sits between an external pin and a bit-to-pixel assembler.

## Interface
- `CLK_FREQ_KHZ`, 10000, system clock frequency.
- `T_HI_THRESHOLD_NS`, 500, high width at or above this decodes as 1; below decodes as 0.
- `T_HI_MIN_NS`, 200, shorter high pulses are errors.
- `T_HI_MAX_NS`, 1000, longer high pulses are errors.
- `T_RESET_NS`, 50000, low time that constitutes a reset/latch gap.
- Derived ticks: `CLK_PERIOD_NS = 10^6 / CLK_FREQ_KHZ`; each `X_TICKS = X_NS / CLK_PERIOD_NS` (integer division). Counter width: `$clog2(T_RESET_TICKS + 1)`.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `encoded_input`  in  1  asynchronous WS2812 line.
- `databit`  out  1  decoded bit; valid while `data_valid` = 1, holds its value otherwise.
- `data_valid`  out  1  one-cycle strobe per accepted bit.
- `reset_detected`  out  1  one-cycle strobe per reset gap.
- `pulse_error`  out  1  one-cycle strobe per rejected pulse.

## Operation
- Input passes through the synchronizer; `line` denotes its output. `line_prev` is line delayed by one cycle. Edges are detected from `line`/`line_prev`.
- States: `WAIT_RESET`, `IDLE`, `HIGH`, `LOW`.
- `WAIT_RESET`: counter counts cycles with `line` = 0 and clears to 0 on `line` = 1. At count `T_RESET_TICKS`: pulse `reset_detected`, go to `IDLE`. Entered after reset and after any error, so decoding always restarts frame-aligned.
- `IDLE`: on rising edge, counter := 1 and go to `HIGH`.
- `HIGH`: counter increments while `line` = 1.
  - Counter reaching `T_HI_MAX_TICKS + 1` with line still high: pulse `pulse_error`, go to `WAIT_RESET`.
  - On falling edge with width H = counter:
    - H < `T_HI_MIN_TICKS`: `pulse_error`, go to `WAIT_RESET`.
    - Otherwise `databit` := (H >= `T_HI_THRESHOLD_TICKS`), `data_valid` := 1, counter := 1, go to `LOW`.
- `LOW`: counter increments while `line` = 0.
  - Rising edge: counter := 1, go to `HIGH`. No minimum low time is enforced.
  - Counter reaching `T_RESET_TICKS`: pulse `reset_detected` exactly once, go to `IDLE`.
- Counters saturate and never wrap.
- Reset (`rst_n` = 0 at a clock edge) clears all outputs to 0 and synchronizer flops to 0, and forces state `WAIT_RESET`. This applies mid-pulse as well; a partial pulse is discarded without an error.

## Timing
- Reset values: `databit` 0, `data_valid` 0, `reset_detected` 0, `pulse_error` 0.
- Synchronizer latency is 2 cycles (3 with the filter).
- `data_valid`, `pulse_error` for a short pulse, and `reset_detected` are registered. They assert 1 cycle after the qualifying `line` sample, giving 3 cycles from the input edge (4 with the filter).
- Width boundaries:
  - H = `T_HI_MIN_TICKS` is accepted.
  - H = `T_HI_MAX_TICKS` is accepted.
  - H = `T_HI_THRESHOLD_TICKS` decodes as 1.
- At most one of the three strobes is asserted in any cycle.

## Configuration
- `WS2812_DECODER_GLITCH_FILTER_EN` defined: adds a filter stage after the 2-flop synchronizer. `line` changes only when two consecutive synchronized samples agree, so single-cycle glitches are suppressed and latency increases by 1.
- Not defined: `line` is the 2-flop synchronizer output directly. A 1-cycle glitch is decoded as a pulse, and becomes an error if `T_HI_MIN_TICKS` > 1.

## Structure
- Shared package `ws2812_pkg`: ns-to-tick conversion function, state encoding constants, default timing constants shared with the encoder.
- Sub-module `ws2812_input_sync`: 2-flop synchronizer plus optional filter, outputs `line`.

## Test plan
All scenarios use 10 MHz defaults: min 2, threshold 5, max 10, reset 500 ticks.
- Line low for 500 cycles after reset → one `reset_detected` at cycle 503, no other strobes.
- Encoder-style stream after reset gap: highs 7/3/7, period 11 cycles → `data_valid` ×3 with `databit` 1,0,1, each 3 cycles after its falling edge.
- Widths 1, 2, 4, 5, 10, 11 cycles, each after a reset gap → error, 0, 0, 1, 1, error. The 11-cycle pulse errors while the line is still high.
- After an error, a valid 7-cycle pulse before any 500-cycle low gap → no `data_valid`; after the gap it decodes normally.
- `rst_n` asserted mid-high pulse, released, line kept high → no strobes; `WAIT_RESET` requires a full gap.
- With `WS2812_DECODER_GLITCH_FILTER_EN`: 1-cycle spike in the low gap → no strobe, gap counting continues; `data_valid` latency is 4.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: default line timing, ns-to-tick conversion and
// the receive FSM state encoding used by the decoder.
package ws2812_pkg;

  localparam int DEF_CLK_FREQ_KHZ      = 10000;
  localparam int DEF_T_HI_THRESHOLD_NS = 500;
  localparam int DEF_T_HI_MIN_NS       = 200;
  localparam int DEF_T_HI_MAX_NS       = 1000;
  localparam int DEF_T_RESET_NS        = 50000;

  localparam logic [1:0] ST_WAIT_RESET = 2'd0;
  localparam logic [1:0] ST_IDLE       = 2'd1;
  localparam logic [1:0] ST_HIGH       = 2'd2;
  localparam logic [1:0] ST_LOW        = 2'd3;

  // Whole clock periods contained in ns (truncating).
  function automatic int ns_to_ticks(input int ns, input int clk_freq_khz);
    return ns / (1000000 / clk_freq_khz);
  endfunction

endpackage

// File: rtl/ws2812_input_sync.sv
// Two-flop synchronizer for the WS2812 line; with WS2812_DECODER_GLITCH_FILTER_EN
// a filter stage only lets the line change after two agreeing synchronized samples.
module ws2812_input_sync
  import ws2812_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic line_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is updated with <= so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

`ifdef WS2812_DECODER_GLITCH_FILTER_EN
  logic sync_prev_q;
  logic hold_q;
  logic line_d;

  // NOTE: a default before the conditional keeps this combinational block latch-free.
  always_comb begin
    line_d = hold_q;
    if (sync_q == sync_prev_q) line_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_prev_q <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      sync_prev_q <= sync_q;
      hold_q      <= line_d;
    end
  end

  assign line_o = line_d;
`else
  assign line_o = sync_q;
`endif

endmodule

// File: rtl/ws2812_unipolar_rz_decoder.sv
// WS2812 receive decoder: measures each high pulse, emits one bit per pulse and
// flags reset gaps and malformed pulses. Optional WS2812_DECODER_GLITCH_FILTER_EN.
module ws2812_unipolar_rz_decoder
  import ws2812_pkg::*;
#(
  parameter int CLK_FREQ_KHZ      = DEF_CLK_FREQ_KHZ,
  parameter int T_HI_THRESHOLD_NS = DEF_T_HI_THRESHOLD_NS,
  parameter int T_HI_MIN_NS       = DEF_T_HI_MIN_NS,
  parameter int T_HI_MAX_NS       = DEF_T_HI_MAX_NS,
  parameter int T_RESET_NS        = DEF_T_RESET_NS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic encoded_input,
  output logic databit,
  output logic data_valid,
  output logic reset_detected,
  output logic pulse_error
);

  localparam int T_HI_THRESHOLD_TICKS = ns_to_ticks(T_HI_THRESHOLD_NS, CLK_FREQ_KHZ);
  localparam int T_HI_MIN_TICKS       = ns_to_ticks(T_HI_MIN_NS, CLK_FREQ_KHZ);
  localparam int T_HI_MAX_TICKS       = ns_to_ticks(T_HI_MAX_NS, CLK_FREQ_KHZ);
  localparam int T_RESET_TICKS        = ns_to_ticks(T_RESET_NS, CLK_FREQ_KHZ);
  localparam int CNT_W                = $clog2(T_RESET_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(T_RESET_TICKS);
  localparam logic [CNT_W-1:0] CNT_HI_OV = CNT_W'(T_HI_MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_HI_MN = CNT_W'(T_HI_MIN_TICKS);
  localparam logic [CNT_W-1:0] CNT_HI_TH = CNT_W'(T_HI_THRESHOLD_TICKS);

  logic             line;
  logic             line_prev_q;
  logic             rise, fall;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             databit_q, databit_d;
  logic             valid_q, valid_d;
  logic             rst_det_q, rst_det_d;
  logic             err_q, err_d;

  ws2812_input_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (encoded_input),
    .line_o  (line)
  );

  assign rise    = line & ~line_prev_q;
  assign fall    = ~line & line_prev_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    databit_d = databit_q;
    valid_d   = 1'b0;
    rst_det_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_WAIT_RESET: begin
        if (line) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_RESET) begin
            rst_det_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        // Overlong pulses are rejected as soon as they exceed the max, not at the fall.
        if (line) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_HI_OV) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT_RESET;
          end
        end else if (fall) begin
          if (cnt_q < CNT_HI_MN) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT_RESET;
          end else begin
            databit_d = (cnt_q >= CNT_HI_TH);
            valid_d   = 1'b1;
            cnt_d     = CNT_ONE;
            state_d   = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end else if (!line) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_RESET) begin
            rst_det_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_WAIT_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_RESET;
      cnt_q       <= '0;
      line_prev_q <= 1'b0;
      databit_q   <= 1'b0;
      valid_q     <= 1'b0;
      rst_det_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_prev_q <= line;
      databit_q   <= databit_d;
      valid_q     <= valid_d;
      rst_det_q   <= rst_det_d;
      err_q       <= err_d;
    end
  end

  assign databit        = databit_q;
  assign data_valid     = valid_q;
  assign reset_detected = rst_det_q;
  assign pulse_error    = err_q;

endmodule
